// File: rtl/channel_readout_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// channel_readout_sequencer_pkg
// Shared definitions for the channel readout path: sequencer state encoding and
// the default data width / channel count / select width, which the per-channel
// output mux uses as well so both sides agree on the geometry.
// -----------------------------------------------------------------------------
package channel_readout_sequencer_pkg;

  localparam int DEFAULT_DW        = 16;
  localparam int DEFAULT_INPUTS    = 32;
  localparam int DEFAULT_SEL_WIDTH = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/channel_readout_sequencer_if.sv
// -----------------------------------------------------------------------------
// channel_readout_sequencer_if
// Valid/ready beat stream leaving the sequencer.
//   m_data  : DW-bit channel word
//   m_chan  : channel index of m_data
//   m_last  : beat of the final channel of the set
//   m_valid : beat valid (producer -> consumer)
//   m_ready : beat accepted (consumer -> producer)
// master = sequencer side, slave = serializer/FIFO side.
// -----------------------------------------------------------------------------
interface channel_readout_sequencer_if
  import channel_readout_sequencer_pkg::*;
#(
  parameter int DW        = DEFAULT_DW,
  parameter int Sel_Width = DEFAULT_SEL_WIDTH
);

  logic [DW-1:0]        m_data;
  logic [Sel_Width-1:0] m_chan;
  logic                 m_last;
  logic                 m_valid;
  logic                 m_ready;

  modport master (output m_data, m_chan, m_last, m_valid, input m_ready);
  modport slave  (input m_data, m_chan, m_last, m_valid, output m_ready);

endinterface

// File: rtl/channel_readout_sequencer.sv
// -----------------------------------------------------------------------------
// channel_readout_sequencer
// Walks the select of the per-channel output mux over channels 0..N-1, registers
// each selected word and streams it out with its channel index and a last flag.
//
// Ports:
//   clk          : system clock, rising edge
//   rst_n        : asynchronous active-low reset
//   start        : one-cycle readout request, honoured only in IDLE
//   num_channels : channel count N, latched (and clamped to Inputs) on start
//   mux_data     : mux output for the current sel
//   sel          : registered select to the mux
//   busy         : high while a readout is in progress (RUN or DRAIN)
//   done         : one-cycle pulse after the final beat is accepted
//   m            : outgoing beat stream (master modport)
// -----------------------------------------------------------------------------
module channel_readout_sequencer
  import channel_readout_sequencer_pkg::*;
#(
  parameter int DW        = DEFAULT_DW,
  parameter int Inputs    = DEFAULT_INPUTS,
  parameter int Sel_Width = DEFAULT_SEL_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [Sel_Width:0]   num_channels,
  input  logic [DW-1:0]        mux_data,
  output logic [Sel_Width-1:0] sel,
  output logic                 busy,
  output logic                 done,
  channel_readout_sequencer_if.master m
);

  localparam logic [Sel_Width:0]   MAX_COUNT = (Sel_Width+1)'(Inputs);
  localparam logic [Sel_Width:0]   CNT_ONE   = (Sel_Width+1)'(1);
  localparam logic [Sel_Width-1:0] SEL_ONE   = Sel_Width'(1);

  state_t               state_reg;
  logic [Sel_Width:0]   count_reg;
  logic [Sel_Width-1:0] sel_reg;
  logic [DW-1:0]        m_data_reg;
  logic [Sel_Width-1:0] m_chan_reg;
  logic                 m_last_reg;
  logic                 m_valid_reg;
  logic                 done_reg;

  logic [Sel_Width-1:0] last_sel;
  logic                 capture;

  // count is never 0 outside IDLE, so count-1 always fits the select width.
  assign last_sel = Sel_Width'(count_reg - CNT_ONE);
  // Output register is free when empty or being drained this cycle.
  assign capture  = !m_valid_reg || m.m_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      count_reg   <= '0;
      sel_reg     <= '0;
      m_data_reg  <= '0;
      m_chan_reg  <= '0;
      m_last_reg  <= 1'b0;
      m_valid_reg <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            if (num_channels == '0) begin
              // Empty set: acknowledge immediately without issuing beats.
              done_reg <= 1'b1;
            end else begin
              state_reg <= RUN;
              sel_reg   <= '0;
              count_reg <= (num_channels > MAX_COUNT) ? MAX_COUNT : num_channels;
            end
          end
        end
        RUN: begin
          if (capture) begin
            m_data_reg  <= mux_data;
            m_chan_reg  <= sel_reg;
            m_last_reg  <= (sel_reg == last_sel);
            m_valid_reg <= 1'b1;
            if (sel_reg == last_sel) begin
              state_reg <= DRAIN;
            end else begin
              sel_reg <= sel_reg + SEL_ONE;
            end
          end
        end
        DRAIN: begin
          // Only the final beat can be held here; wait for it to leave.
          if (m_valid_reg && m.m_ready && m_last_reg) begin
            m_valid_reg <= 1'b0;
            m_last_reg  <= 1'b0;
            sel_reg     <= '0;
            state_reg   <= IDLE;
            done_reg    <= 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign sel       = sel_reg;
  assign busy      = (state_reg != IDLE);
  assign done      = done_reg;
  assign m.m_data  = m_data_reg;
  assign m.m_chan  = m_chan_reg;
  assign m.m_last  = m_last_reg;
  assign m.m_valid = m_valid_reg;

endmodule

// File: tb/tb_channel_readout_sequencer.sv
// -----------------------------------------------------------------------------
// tb_channel_readout_sequencer
// Directed bench for channel_readout_sequencer. A behavioural mux returns
// 16'h1000 + sel. Each start pushes the expected beats (and done timing) into a
// scoreboard; a negedge monitor pops and compares accepted beats and done pulses
// and checks that a stalled beat and sel stay frozen.
// -----------------------------------------------------------------------------
module tb_channel_readout_sequencer;

  localparam int DW = 16;
  localparam int SW = 5;
  localparam int NIN = 32;

  typedef struct {
    logic [DW-1:0] data;
    logic [SW-1:0] chan;
    logic          last;
    int            cyc;   // required cycle of acceptance, -1 = don't care
  } beat_t;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [SW:0]   num_channels;
  logic [DW-1:0] mux_data;
  logic [SW-1:0] sel;
  logic          busy;
  logic          done;

  channel_readout_sequencer_if #(.DW(DW), .Sel_Width(SW)) bus ();

  channel_readout_sequencer #(.DW(DW), .Inputs(NIN), .Sel_Width(SW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .num_channels (num_channels),
    .mux_data     (mux_data),
    .sel          (sel),
    .busy         (busy),
    .done         (done),
    .m            (bus)
  );

  // Channel mux model.
  assign mux_data = 16'h1000 + DW'(sel);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  beat_t sb[$];
  int    done_q[$];
  int    errors = 0;
  int    checks = 0;
  int    beats  = 0;

  // Stall tracking for the hold check.
  logic          stall_prev = 1'b0;
  logic [DW-1:0] prev_data;
  logic [SW-1:0] prev_chan;
  logic          prev_last;
  logic [SW-1:0] prev_sel;

  always @(negedge clk) begin
    beat_t exp_b;
    int    exp_c;
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        checks++;
        assert ({bus.m_valid, bus.m_data, bus.m_chan, bus.m_last, sel} ===
                {1'b1, prev_data, prev_chan, prev_last, prev_sel})
        else begin
          errors++;
          $error("FAIL stall_hold observed v=%0b d=%h c=%0d l=%0b s=%0d required v=1 d=%h c=%0d l=%0b s=%0d",
                 bus.m_valid, bus.m_data, bus.m_chan, bus.m_last, sel,
                 prev_data, prev_chan, prev_last, prev_sel);
        end
      end
      if (bus.m_valid && bus.m_ready) begin
        beats++;
        $display("beat cycle=%0d chan=%0d data=%h last=%0b", cyc, bus.m_chan, bus.m_data, bus.m_last);
        checks++;
        assert (sb.size() != 0)
        else begin
          errors++;
          $error("FAIL unexpected_beat observed chan=%0d required no beat", bus.m_chan);
        end
        if (sb.size() != 0) begin
          exp_b = sb.pop_front();
          checks++;
          assert ({bus.m_data, bus.m_chan, bus.m_last} === {exp_b.data, exp_b.chan, exp_b.last})
          else begin
            errors++;
            $error("FAIL beat observed d=%h c=%0d l=%0b required d=%h c=%0d l=%0b",
                   bus.m_data, bus.m_chan, bus.m_last, exp_b.data, exp_b.chan, exp_b.last);
          end
          if (exp_b.cyc >= 0) begin
            checks++;
            assert (cyc === exp_b.cyc)
            else begin
              errors++;
              $error("FAIL beat_cycle observed %0d required %0d", cyc, exp_b.cyc);
            end
          end
        end
      end
      if (done) begin
        $display("done cycle=%0d", cyc);
        checks++;
        assert (!busy)
        else begin
          errors++;
          $error("FAIL done_busy observed busy=%0b required 0", busy);
        end
        checks++;
        assert (done_q.size() != 0)
        else begin
          errors++;
          $error("FAIL unexpected_done observed cycle=%0d required no done", cyc);
        end
        if (done_q.size() != 0) begin
          exp_c = done_q.pop_front();
          if (exp_c >= 0) begin
            checks++;
            assert (cyc === exp_c)
            else begin
              errors++;
              $error("FAIL done_cycle observed %0d required %0d", cyc, exp_c);
            end
          end
        end
      end
      stall_prev = bus.m_valid && !bus.m_ready;
      prev_data  = bus.m_data;
      prev_chan  = bus.m_chan;
      prev_last  = bus.m_last;
      prev_sel   = sel;
    end
  end

  // Issue a start and push the beats/done it must produce.
  task automatic start_run(input int n, input bit timed);
    int s;
    int eff;
    beat_t b;
    @(posedge clk);
    #1;
    start        = 1'b1;
    num_channels = (SW+1)'(n);
    s            = cyc;
    eff          = (n > NIN) ? NIN : n;
    for (int i = 0; i < eff; i++) begin
      b.data = 16'h1000 + DW'(i);
      b.chan = SW'(i);
      b.last = (i == eff - 1);
      b.cyc  = timed ? s + 2 + i : -1;
      sb.push_back(b);
    end
    done_q.push_back(timed ? ((eff == 0) ? s + 1 : s + eff + 2) : -1);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Run until the scoreboard drains (bounded), optionally toggling m_ready.
  task automatic wait_idle(input bit bp, input int budget, input string tag);
    int i;
    i = 0;
    while ((sb.size() != 0 || done_q.size() != 0) && i < budget) begin
      @(posedge clk);
      #1;
      bus.m_ready = bp ? ((i % 4 == 0) || (i % 4 == 3)) : 1'b1;
      i++;
    end
    bus.m_ready = 1'b1;
    checks++;
    assert (sb.size() == 0 && done_q.size() == 0)
    else begin
      errors++;
      $error("FAIL %s_timeout observed pending beats=%0d dones=%0d required 0 0", tag, sb.size(), done_q.size());
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    assert (busy === 1'b0)
    else begin
      errors++;
      $error("FAIL %s_idle observed busy=%0b required 0", tag, busy);
    end
  endtask

  initial begin
    int base;
    int i;
    rst_n        = 1'b0;
    start        = 1'b0;
    num_channels = '0;
    bus.m_ready  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    assert ({sel, bus.m_data, bus.m_chan, bus.m_last, bus.m_valid, busy, done} === '0)
    else begin
      errors++;
      $error("FAIL reset_values observed sel=%0d d=%h c=%0d l=%0b v=%0b busy=%0b done=%0b required all 0",
             sel, bus.m_data, bus.m_chan, bus.m_last, bus.m_valid, busy, done);
    end
    rst_n = 1'b1;

    // Full readout, timed.
    start_run(32, 1'b1);
    wait_idle(1'b0, 100, "full");

    // Back-pressure.
    start_run(4, 1'b0);
    wait_idle(1'b1, 100, "bp");

    // Edge counts.
    start_run(0, 1'b1);
    wait_idle(1'b0, 20, "n0");
    start_run(1, 1'b1);
    wait_idle(1'b0, 20, "n1");
    start_run(40, 1'b1);
    wait_idle(1'b0, 100, "n40");

    // Start while busy, with num_channels changed mid-run.
    start_run(5, 1'b1);
    @(posedge clk);
    #1;
    start        = 1'b1;
    num_channels = (SW+1)'(8);
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_idle(1'b0, 50, "busy_start");

    // Asynchronous reset in the middle of a run.
    base = beats;
    start_run(10, 1'b0);
    i = 0;
    while (beats < base + 3 && i < 50) begin
      @(posedge clk);
      #1;
      i++;
    end
    checks++;
    assert (beats >= base + 3)
    else begin
      errors++;
      $error("FAIL rst_wait observed beats=%0d required %0d", beats - base, 3);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    assert ({sel, bus.m_data, bus.m_chan, bus.m_last, bus.m_valid, busy, done} === '0)
    else begin
      errors++;
      $error("FAIL async_reset observed sel=%0d d=%h c=%0d l=%0b v=%0b busy=%0b done=%0b required all 0",
             sel, bus.m_data, bus.m_chan, bus.m_last, bus.m_valid, busy, done);
    end
    sb.delete();
    done_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    start_run(2, 1'b1);
    wait_idle(1'b0, 20, "after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
